// File: rtl/multi_sum_nv.sv
// multi_sum_nv - pipelined signed adder tree for any channel count.
//
// Purpose:
//   Sums N_args signed channels through a registered pairwise adder tree.
//   The design applies a per-channel enable mask, an arithmetic right shift
//   with round-half-up, and then reduces the result to out_width bits. Each
//   sample carries its own mask and shift through the pipeline. Latency from
//   the we edge to valid is LVL+2 cycles, and one sample is accepted per cycle.
//
// Ports:
//   clk       clock
//   resetn    asynchronous active-low reset
//   we        input sample strobe
//   args_in   N_args signed channels, channel k at [(k+1)*in_width-1 : k*in_width]
//   mask      channel enables, 1 = channel k included
//   shift     right-shift amount, clamped to FULL-1
//   sum_out   signed result, held between valid pulses
//   valid     one-cycle pulse per accepted sample
//   overflow  result was clipped (saturating build only)
//
// Build option:
//   MULTI_SUM_SAT_EN  defined: results out of range clip to the bound and raise
//                     overflow. Undefined: results wrap and overflow is 0.

module multi_sum_nv #(
    parameter int unsigned N_args    = 5,
    parameter int unsigned in_width  = 12,
    parameter int unsigned out_width = 14,
    parameter int unsigned sh_width  = 4
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         we,
    input  logic [N_args*in_width-1:0]   args_in,
    input  logic [N_args-1:0]            mask,
    input  logic [sh_width-1:0]          shift,
    output logic [out_width-1:0]         sum_out,
    output logic                         valid,
    output logic                         overflow
);

    localparam int unsigned LVL  = (N_args <= 1) ? 0 : $clog2(N_args);
    localparam int unsigned FULL = in_width + LVL;

    // Number of tree nodes at level l. An odd node count rounds up because
    // the leftover node passes through unchanged.
    function automatic int unsigned cnt_at(int unsigned l);
        int unsigned c;
        c = N_args;
        for (int unsigned i = 0; i < l; i++) c = (c + 1) / 2;
        return c;
    endfunction

    // vld[l] is set when tree level l holds a freshly loaded sample.
    logic [LVL:0] vld;
    logic         vld_rnd;

    // ------------------------------------------------------------------
    // Tree levels. Level 0 is the masked input capture. Each level stores
    // its nodes packed, is one bit wider than the level before it, and
    // carries the shift value of the sample it holds.
    // ------------------------------------------------------------------
    for (genvar l = 0; l <= LVL; l++) begin : g_lvl
        localparam int unsigned CNT = cnt_at(l);
        localparam int unsigned W   = in_width + l;

        logic [CNT*W-1:0]    node;
        logic [CNT*W-1:0]    node_nxt;
        logic [sh_width-1:0] sh;

        if (l == 0) begin : g_cap
            for (genvar k = 0; k < N_args; k++) begin : g_ch
                assign node_nxt[k*in_width +: in_width] =
                    mask[k] ? args_in[k*in_width +: in_width] : '0;
            end

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    node <= '0;
                    sh   <= '0;
                end else if (we) begin
                    node <= node_nxt;
                    sh   <= shift;
                end
            end
        end else begin : g_add
            localparam int unsigned PCNT = cnt_at(l - 1);
            localparam int unsigned PW   = W - 1;

            logic [PCNT*PW-1:0] prev;
            assign prev = g_lvl[l-1].node;

            for (genvar i = 0; i < CNT; i++) begin : g_node
                if (2*i + 1 < PCNT) begin : g_pair
                    assign node_nxt[i*W +: W] =
                        {prev[(2*i+1)*PW-1], prev[2*i*PW +: PW]} +
                        {prev[(2*i+2)*PW-1], prev[(2*i+1)*PW +: PW]};
                end else begin : g_pass
                    assign node_nxt[i*W +: W] =
                        {prev[(2*i+1)*PW-1], prev[2*i*PW +: PW]};
                end
            end

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    node <= '0;
                    sh   <= '0;
                end else if (vld[l-1]) begin
                    node <= node_nxt;
                    sh   <= g_lvl[l-1].sh;
                end
            end
        end
    end

    // The valid chain advances every cycle. The data registers load only
    // when their incoming valid bit is set.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vld     <= '0;
            vld_rnd <= 1'b0;
        end else begin
            vld[0] <= we;
            for (int unsigned l = 1; l <= LVL; l++) vld[l] <= vld[l-1];
            vld_rnd <= vld[LVL];
        end
    end

    // ------------------------------------------------------------------
    // Rounding stage: (sum + 2^(sh-1)) >>> sh, with sh clamped to FULL-1.
    // The sum is extended by one bit so the rounding bias cannot overflow.
    // The rounding stage and the width reduction are registered separately,
    // which gives the LVL+2 latency.
    // ------------------------------------------------------------------
    logic [FULL-1:0]        sum_full;
    logic [sh_width-1:0]    sh_last;
    int unsigned            sh_eff;
    logic signed [FULL:0]   ext;
    logic signed [FULL:0]   bias;
    logic signed [FULL:0]   biased;
    logic signed [FULL:0]   shifted;
    logic [FULL-1:0]        rnd;

    assign sum_full = g_lvl[LVL].node;
    assign sh_last  = g_lvl[LVL].sh;

    always_comb begin
        sh_eff  = 32'(sh_last);
        if (sh_eff > FULL - 1) sh_eff = FULL - 1;
        ext     = {sum_full[FULL-1], sum_full};
        bias    = '0;
        biased  = ext;
        shifted = ext;
        if (sh_eff != 0) begin
            bias[sh_eff-1] = 1'b1;
            biased         = ext + bias;
            shifted        = biased >>> sh_eff;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rnd <= '0;
        end else if (vld[LVL]) begin
            rnd <= shifted[FULL-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Output stage: reduce to out_width bits.
    // ------------------------------------------------------------------
    logic [out_width-1:0] out_nxt;
    logic                 unused_bits;

`ifdef MULTI_SUM_SAT_EN
    logic in_range;

    // The value fits when every bit above the out_width sign bit matches
    // that sign bit.
    always_comb begin
        in_range = (rnd[FULL-1:out_width-1] == {(FULL-out_width+1){rnd[FULL-1]}});
        if (in_range)
            out_nxt = rnd[out_width-1:0];
        else if (rnd[FULL-1])
            out_nxt = {1'b1, {(out_width-1){1'b0}}};
        else
            out_nxt = {1'b0, {(out_width-1){1'b1}}};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) overflow <= 1'b0;
        else         overflow <= vld_rnd & ~in_range;
    end

    assign unused_bits = shifted[FULL];
`else
    assign out_nxt  = rnd[out_width-1:0];
    assign overflow = 1'b0;

    if (out_width < FULL) begin : g_wrap_hi
        assign unused_bits = ^{shifted[FULL], rnd[FULL-1:out_width]};
    end else begin : g_wrap_full
        assign unused_bits = shifted[FULL];
    end
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sum_out <= '0;
            valid   <= 1'b0;
        end else begin
            valid <= vld_rnd;
            if (vld_rnd) sum_out <= out_nxt;
        end
    end

endmodule

// File: tb/tb_multi_sum_nv.sv
// tb_multi_sum_nv - self-checking bench for multi_sum_nv.
// It drives a 5-channel instance and a 1-channel instance with the same
// stimulus, and compares their outputs every cycle against an arithmetic
// reference model.

module tb_multi_sum_nv;

    localparam int N     = 5;
    localparam int IW    = 12;
    localparam int OW    = 14;
    localparam int SW    = 4;
    localparam int LAT   = 5;
    localparam int FULL  = 15;
    localparam int OW1   = 12;
    localparam int LAT1  = 2;
    localparam int FULL1 = 12;

    logic                clk = 1'b0;
    logic                resetn;
    logic                we;
    logic [N*IW-1:0]     args_in;
    logic [N-1:0]        mask;
    logic [SW-1:0]       shift;
    logic [OW-1:0]       sum_out;
    logic                valid;
    logic                overflow;

    logic [IW-1:0]       args1;
    logic [0:0]          mask1;
    logic [OW1-1:0]      sum1;
    logic                valid1;
    logic                ovf1;

    always #5 clk = ~clk;

    multi_sum_nv #(.N_args(N), .in_width(IW), .out_width(OW), .sh_width(SW)) u_dut (
        .clk(clk), .resetn(resetn), .we(we), .args_in(args_in), .mask(mask),
        .shift(shift), .sum_out(sum_out), .valid(valid), .overflow(overflow)
    );

    multi_sum_nv #(.N_args(1), .in_width(IW), .out_width(OW1), .sh_width(SW)) u_dut1 (
        .clk(clk), .resetn(resetn), .we(we), .args_in(args1), .mask(mask1),
        .shift(shift), .sum_out(sum1), .valid(valid1), .overflow(ovf1)
    );

    typedef struct {
        int     due;
        longint val;
        bit     ov;
    } exp_t;

    exp_t   q5[$];
    exp_t   q1[$];
    longint last5;
    longint last1;
    int     cyc;
    int     n_checks;
    int     n_fail;

    task automatic check(string tag, longint got, longint exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic longint floor_div(longint a, longint d);
        longint q;
        q = a / d;
        if ((a % d != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    // Reference: masked sum, then round half up, then clip or wrap.
    function automatic void ref_result(int ch[N], logic [N-1:0] m, int sh, int n,
                                       int ow, int full, output longint r, output bit ov);
        longint s, d, lo, hi, md;
        int     sc;
        s = 0;
        for (int k = 0; k < n; k++) if (m[k]) s += ch[k];
        sc = (sh > full - 1) ? full - 1 : sh;
        if (sc > 0) begin
            d = longint'(1) << sc;
            s = floor_div(s + d / 2, d);
        end
        hi = (longint'(1) << (ow - 1)) - 1;
        lo = -(longint'(1) << (ow - 1));
        ov = 1'b0;
`ifdef MULTI_SUM_SAT_EN
        if (s > hi) begin s = hi; ov = 1'b1; end
        else if (s < lo) begin s = lo; ov = 1'b1; end
`else
        md = longint'(1) << ow;
        s  = ((s % md) + md) % md;
        if (s > hi) s = s - md;
`endif
        r = s;
    endfunction

    function automatic int rand_ch();
        case ($urandom_range(0, 7))
            0:       return -2048;
            1:       return 2047;
            default: return int'($urandom_range(0, 4095)) - 2048;
        endcase
    endfunction

    task automatic check_outputs();
        exp_t   e;
        bit     ev;
        longint es;
        bit     eo;
        if (q5.size() > 0 && q5[0].due == cyc) begin
            e = q5.pop_front(); ev = 1'b1; es = e.val; eo = e.ov; last5 = es;
        end else begin
            ev = 1'b0; es = last5; eo = 1'b0;
        end
        check("valid", valid, ev);
        check("sum_out", $signed(sum_out), es);
        check("overflow", overflow, eo);

        if (q1.size() > 0 && q1[0].due == cyc) begin
            e = q1.pop_front(); ev = 1'b1; es = e.val; eo = e.ov; last1 = es;
        end else begin
            ev = 1'b0; es = last1; eo = 1'b0;
        end
        check("valid_n1", valid1, ev);
        check("sum_out_n1", $signed(sum1), es);
        check("overflow_n1", ovf1, eo);
    endtask

    task automatic step(bit w, int ch[N], logic [N-1:0] m, int sh);
        longint r;
        bit     o;
        we = w;
        for (int k = 0; k < N; k++) args_in[k*IW +: IW] = ch[k][IW-1:0];
        mask  = m;
        shift = SW'(sh);
        args1 = ch[0][IW-1:0];
        mask1 = m[0];
        @(posedge clk);
        cyc++;
        if (w && resetn) begin
            ref_result(ch, m, sh, N, OW, FULL, r, o);
            q5.push_back('{cyc + LAT, r, o});
            ref_result(ch, m, sh, 1, OW1, FULL1, r, o);
            q1.push_back('{cyc + LAT1, r, o});
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic send5(int a, int b, int c, int d, int e, logic [N-1:0] m, int sh);
        int ch[N];
        ch = '{a, b, c, d, e};
        step(1'b1, ch, m, sh);
    endtask

    task automatic random_step(bit w);
        int ch[N];
        foreach (ch[k]) ch[k] = rand_ch();
        step(w, ch, N'($urandom), int'($urandom_range(0, 15)));
    endtask

    task automatic idle(int n);
        repeat (n) random_step(1'b0);
    endtask

    task automatic pulse_reset(int n);
        resetn = 1'b0;
        #1;
        check("rst_valid", valid, 0);
        check("rst_sum_out", $signed(sum_out), 0);
        check("rst_overflow", overflow, 0);
        check("rst_valid_n1", valid1, 0);
        check("rst_sum_out_n1", $signed(sum1), 0);
        q5.delete();
        q1.delete();
        last5 = 0;
        last1 = 0;
        repeat (n) random_step(1'b1);
        resetn = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        last5    = 0;
        last1    = 0;
        resetn   = 1'b0;
        we       = 1'b0;
        args_in  = '0;
        mask     = '0;
        shift    = '0;
        args1    = '0;
        mask1    = '0;

        // Reset held for 2 cycles while random samples are strobed in.
        repeat (2) random_step(1'b1);
        resetn = 1'b1;

        // Directed cases.
        send5(2047, 2047, 2047, 2047, 2047, 5'b11111, 0);
        send5(100, -50, 7, 0, 3, 5'b10101, 0);
        send5(100, -50, 7, 0, 3, 5'b10101, 2);
        send5(-2048, -2048, -2048, -2048, -2048, 5'b11111, 1);
        send5(1234, -999, 55, 2047, -2048, 5'b00000, 3);
        send5(-2048, -2048, -2048, -2048, -2048, 5'b11111, 15);
        send5(2047, 2047, 2047, 2047, 2047, 5'b11111, 14);
        send5(-7, 500, 500, 500, 500, 5'b00001, 0);
        send5(-2048, -2048, -2048, -2048, -2048, 5'b11111, 0);
        idle(LAT + 1);

        // A we gap: the middle sample, with sum 20, is not accepted.
        send5(10, 0, 0, 0, 0, 5'b11111, 0);
        begin
            int ch[N];
            ch = '{20, 0, 0, 0, 0};
            step(1'b0, ch, 5'b11111, 0);
        end
        send5(30, 0, 0, 0, 0, 5'b11111, 0);
        idle(LAT + 1);

        // Reset while three samples are in flight.
        send5(1, 2, 3, 4, 5, 5'b11111, 0);
        send5(-1, -2, -3, -4, -5, 5'b11111, 0);
        send5(7, 7, 7, 7, 7, 5'b11111, 0);
        pulse_reset(1);
        idle(LAT + 2);
        send5(11, 22, 33, 44, 55, 5'b11111, 1);
        idle(LAT + 1);

        // Random traffic.
        repeat (400) random_step($urandom_range(0, 3) != 0);
        idle(LAT + 1);

        check("queue_drained", q5.size(), 0);
        check("queue_drained_n1", q1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_sum_nv.md
Name: multi_sum_nv

Overview:
Pipelined signed adder tree for CRPA beamformer channel combining; generalises the power-of-two adder tree to any channel count. Adds a per-channel enable mask, valid propagation with hold, a runtime arithmetic right-shift with rounding, and a selectable output width. Sits after the per-channel weighting multipliers and feeds the correlator input.

Parameters:
N_args, 5, number of signed input channels (1..64); no power-of-two requirement.
in_width, 12, width of each signed input.
out_width, 14, width of the signed output (2..in_width+LVL).
sh_width, 4, width of the shift control.
Derived: LVL = CLOG2(N_args) (0 when N_args=1); FULL = in_width+LVL; LAT = LVL+2.

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
we  in  1  input sample strobe
args_in  in  N_args*in_width  channel k in bits [(k+1)*in_width-1 : k*in_width], signed
mask  in  N_args  1 = channel k included; 0 = treated as zero
shift  in  sh_width  right-shift amount applied to the full sum
sum_out  out  out_width  signed result
valid  out  1  sum_out holds a new result this cycle
overflow  out  1  result exceeded out_width range (sticky per sample, see feature)

Behaviour:
- Reset: clk and resetn only; resetn is asynchronous and active-low. All pipeline registers, the valid chain, sum_out, valid and overflow clear to 0 immediately on assertion, and stay 0 until the first post-release sample reaches the output.
- Stage 0: on a clk edge with we=1, capture the masked inputs. A masked channel is 0, not its input value. Capture shift with the same sample. With we=0, stage 0 holds its contents.
- Tree stages 1..LVL: pairwise signed adds, each level one bit wider. An odd element at a level passes through registered. No zero-padding of inputs to a power of two.
- Each stage register loads only when its incoming valid bit is 1; otherwise it holds. The valid chain shifts every cycle.
- Output stage, at LAT cycles after the we edge:
  - shift=0: r = sum.
  - shift>0: r = (sum + 2^(shift-1)) >>> shift (round half up, arithmetic). shift is clamped to FULL-1.
- r is then reduced to out_width per the Optional Feature. valid=1 for exactly one cycle per accepted sample.
- Throughput: one sample per cycle. Back-to-back we gives back-to-back valid. A we gap gives a valid gap; sum_out keeps its last value during the gap.
- Mask and shift are coherent per sample: changing them between samples never mixes values within one sample.
- Boundary cases:
  - N_args=1: pass-through with LAT=2.
  - mask all zero: result 0 with valid=1.
  - Reset mid-stream: in-flight samples are discarded; no stale valid after release.

Optional Feature:
MULTI_SUM_SAT_EN
- Defined: r outside [-2^(out_width-1), 2^(out_width-1)-1] clips to the nearest bound, and overflow=1 in the same cycle as that valid. overflow is 0 for in-range results and 0 when valid=0.
- Undefined: r wraps (low out_width bits kept) and overflow is tied to 0.
- Latency is identical in both builds.

Test Plan:
Defaults (N_args=5, in_width=12, out_width=14, LAT=5) unless stated.
1. resetn=0 for 2 cycles, we=1 with random data -> sum_out=0, valid=0, overflow=0 throughout. First valid appears 5 cycles after the first post-release we edge.
2. All inputs 2047, mask 11111, shift 0 -> full sum 10235. With SAT_EN: sum_out=8191, overflow=1. Without: sum_out=-6149, overflow=0.
3. Inputs (ch0..ch4) 100, -50, 7, 0, 3; mask 10101 -> shift 0 gives 110; shift 2 gives 28 ((110+2)>>>2).
4. All inputs -2048, mask 11111, shift 1 -> (-10240+1)>>>1 = -5120, overflow=0.
5. we pattern 1,0,1 with sums 10, 20, 30 -> valid 1,0,1 on cycles 5..7; sum_out 10, holds 10, then 30.
6. Three samples in flight, resetn pulsed low for 1 cycle -> valid and sum_out go to 0 at once; after release no valid until a new we plus 5 cycles.
7. N_args=1 build, input -7, mask 1 -> sum_out=-7 after 2 cycles.
